// File: rtl/mips_pkg.sv
// mips_pkg: opcode, ALU-class and forward-select encodings
// plus the per-instruction control bundle shared by pipe_ctrl.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef struct packed {
      logic       reg_dst;
      logic       alu_src;
      logic [1:0] alu_op;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       mem_to_reg;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode to control-bundle decoder.
// Also reports whether the instruction reads its rt field.
module ctrl_decode
   import mips_pkg::*;
(
   input  logic [5:0] i_op,
   output ctrl_t      o_ctrl,
   output logic       o_rt_used
);

   // Opcode table; unknown opcodes decode to an all-zero bundle
   always_comb begin
      o_ctrl    = CTRL_NOP;
      o_rt_used = 1'b0;
      unique case (i_op)
         OP_RTYPE: begin
            o_ctrl.reg_dst   = 1'b1;
            o_ctrl.reg_write = 1'b1;
            o_ctrl.alu_op    = ALU_FUNCT;
            o_rt_used        = 1'b1;
         end
         OP_LW: begin
            o_ctrl.alu_src    = 1'b1;
            o_ctrl.mem_read   = 1'b1;
            o_ctrl.mem_to_reg = 1'b1;
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.alu_op     = ALU_ADD;
         end
         OP_SW: begin
            o_ctrl.alu_src   = 1'b1;
            o_ctrl.mem_write = 1'b1;
            o_ctrl.alu_op    = ALU_ADD;
            o_rt_used        = 1'b1;
         end
         OP_BEQ: begin
            o_ctrl.alu_op = ALU_SUB;
            o_rt_used     = 1'b1;
         end
         OP_ADDI: begin
            o_ctrl.alu_src   = 1'b1;
            o_ctrl.reg_write = 1'b1;
            o_ctrl.alu_op    = ALU_ADD;
         end
         default: begin
            o_ctrl    = CTRL_NOP;
            o_rt_used = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: control pipeline, hazard and forwarding unit for 5-stage MIPS.
// Define PIPE_CTRL_FORWARDING_EN for operand forwarding (load-use stalls only).
module pipe_ctrl
   import mips_pkg::*;
#(
   parameter int IWIDTH = 32,
   parameter int AWIDTH = 5
) (
   input  logic              c_clk,
   input  logic              c_rst,
   input  logic              c_i_ce,
   input  logic [IWIDTH-1:0] c_i_instr,
   input  logic              c_i_branch_taken,
   output logic              c_o_stall,
   output logic              c_o_flush,
   output logic              c_o_RegDst,
   output logic              c_o_ALUSrc,
   output logic [1:0]        c_o_alu_op,
   output logic              c_o_MemRead,
   output logic              c_o_MemWrite,
   output logic              c_o_RegWrite,
   output logic              c_o_MemtoReg,
   output logic [AWIDTH-1:0] c_o_wb_addr,
   output logic [1:0]        c_o_fwd_a,
   output logic [1:0]        c_o_fwd_b
);

   ctrl_t             w_dec;
   logic              w_rt_used;
   logic [AWIDTH-1:0] w_rs;
   logic [AWIDTH-1:0] w_rt;
   logic [AWIDTH-1:0] w_rd;
   logic [AWIDTH-1:0] w_dst;
   logic              w_hazard;
   logic              w_stall;
   logic              w_flush;
   logic              w_unused;

   ctrl_t             r_idex_ctrl;
   logic [AWIDTH-1:0] r_idex_dst;
   logic [AWIDTH-1:0] r_idex_rs;
   logic [AWIDTH-1:0] r_idex_rt;

   logic              r_exmem_mem_read;
   logic              r_exmem_mem_write;
   logic              r_exmem_reg_write;
   logic              r_exmem_mem_to_reg;
   logic [AWIDTH-1:0] r_exmem_dst;

   logic              r_memwb_reg_write;
   logic              r_memwb_mem_to_reg;
   logic [AWIDTH-1:0] r_memwb_dst;

   // True when a stage writing i_d feeds a source read by IF/ID
   function automatic logic f_dep(
      input logic              i_we,
      input logic [AWIDTH-1:0] i_d,
      input logic [AWIDTH-1:0] i_rs,
      input logic [AWIDTH-1:0] i_rt,
      input logic              i_rt_used
   );
      return i_we && (i_d != '0) &&
             ((i_d == i_rs) || (i_rt_used && (i_d == i_rt)));
   endfunction

   ctrl_decode u_dec (
      .i_op      (c_i_instr[IWIDTH-1 -: 6]),
      .o_ctrl    (w_dec),
      .o_rt_used (w_rt_used)
   );

   assign w_rs = c_i_instr[21 +: AWIDTH];
   assign w_rt = c_i_instr[16 +: AWIDTH];
   assign w_rd = c_i_instr[11 +: AWIDTH];

   // Non-writing instructions carry destination 0 down the pipe
   assign w_dst = !w_dec.reg_write ? '0 :
                  (w_dec.reg_dst ? w_rd : w_rt);

`ifdef PIPE_CTRL_FORWARDING_EN
   function automatic logic [1:0] f_fwd(
      input logic [AWIDTH-1:0] i_src,
      input logic              i_mwe,
      input logic [AWIDTH-1:0] i_md,
      input logic              i_wwe,
      input logic [AWIDTH-1:0] i_wd
   );
      if (i_mwe && (i_md != '0) && (i_md == i_src))
         return FWD_MEM;
      if (i_wwe && (i_wd != '0) && (i_wd == i_src))
         return FWD_WB;
      return FWD_RF;
   endfunction

   assign w_hazard = r_idex_ctrl.mem_read &&
                     f_dep(r_idex_ctrl.reg_write, r_idex_dst,
                           w_rs, w_rt, w_rt_used);

   assign c_o_fwd_a = f_fwd(r_idex_rs,
                            r_exmem_reg_write, r_exmem_dst,
                            r_memwb_reg_write, r_memwb_dst);
   assign c_o_fwd_b = f_fwd(r_idex_rt,
                            r_exmem_reg_write, r_exmem_dst,
                            r_memwb_reg_write, r_memwb_dst);

   assign w_unused = ^{c_i_instr[10:0]};
`else
   assign w_hazard =
      f_dep(r_idex_ctrl.reg_write, r_idex_dst,
            w_rs, w_rt, w_rt_used) ||
      f_dep(r_exmem_reg_write, r_exmem_dst,
            w_rs, w_rt, w_rt_used) ||
      f_dep(r_memwb_reg_write, r_memwb_dst,
            w_rs, w_rt, w_rt_used);

   assign c_o_fwd_a = FWD_RF;
   assign c_o_fwd_b = FWD_RF;

   assign w_unused = ^{c_i_instr[10:0], r_idex_rs, r_idex_rt};
`endif

   assign w_flush = c_i_ce && c_i_branch_taken;
   assign w_stall = c_i_ce && !c_i_branch_taken && w_hazard;

   assign c_o_flush = w_flush;
   assign c_o_stall = w_stall;

   // Advance ID/EX -> EX/MEM -> MEM/WB; stall or flush bubbles ID/EX
   always_ff @(posedge c_clk or negedge c_rst) begin
      if (!c_rst) begin
         r_idex_ctrl        <= CTRL_NOP;
         r_idex_dst         <= '0;
         r_idex_rs          <= '0;
         r_idex_rt          <= '0;
         r_exmem_mem_read   <= 1'b0;
         r_exmem_mem_write  <= 1'b0;
         r_exmem_reg_write  <= 1'b0;
         r_exmem_mem_to_reg <= 1'b0;
         r_exmem_dst        <= '0;
         r_memwb_reg_write  <= 1'b0;
         r_memwb_mem_to_reg <= 1'b0;
         r_memwb_dst        <= '0;
      end else if (c_i_ce) begin
         if (w_stall || w_flush) begin
            r_idex_ctrl <= CTRL_NOP;
            r_idex_dst  <= '0;
            r_idex_rs   <= '0;
            r_idex_rt   <= '0;
         end else begin
            r_idex_ctrl <= w_dec;
            r_idex_dst  <= w_dst;
            r_idex_rs   <= w_rs;
            r_idex_rt   <= w_rt;
         end
         r_exmem_mem_read   <= r_idex_ctrl.mem_read;
         r_exmem_mem_write  <= r_idex_ctrl.mem_write;
         r_exmem_reg_write  <= r_idex_ctrl.reg_write;
         r_exmem_mem_to_reg <= r_idex_ctrl.mem_to_reg;
         r_exmem_dst        <= r_idex_dst;
         r_memwb_reg_write  <= r_exmem_reg_write;
         r_memwb_mem_to_reg <= r_exmem_mem_to_reg;
         r_memwb_dst        <= r_exmem_dst;
      end
   end

   assign c_o_RegDst   = r_idex_ctrl.reg_dst;
   assign c_o_ALUSrc   = r_idex_ctrl.alu_src;
   assign c_o_alu_op   = r_idex_ctrl.alu_op;
   assign c_o_MemRead  = r_exmem_mem_read;
   assign c_o_MemWrite = r_exmem_mem_write;
   assign c_o_RegWrite = r_memwb_reg_write;
   assign c_o_MemtoReg = r_memwb_mem_to_reg;
   assign c_o_wb_addr  = r_memwb_dst;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed bench for pipe_ctrl with an instruction-level
// model of the three control stages, checked every falling edge.
module tb_pipe_ctrl;

   localparam logic [31:0] NOP   = 32'h0000_0000;
   localparam logic [31:0] ADD9  = 32'h0108_4820;
   localparam logic [31:0] ADD10 = 32'h0129_5020;
   localparam logic [31:0] LW8   = 32'h8C08_0000;
   localparam logic [31:0] BEQ   = 32'h1000_0001;
   localparam logic [31:0] BUB   = 32'hFC00_0000;

   logic        c_clk = 1'b0;
   logic        c_rst = 1'b0;
   logic        c_i_ce = 1'b1;
   logic [31:0] c_i_instr = NOP;
   logic        c_i_branch_taken = 1'b0;
   logic        c_o_stall, c_o_flush;
   logic        c_o_RegDst, c_o_ALUSrc;
   logic [1:0]  c_o_alu_op;
   logic        c_o_MemRead, c_o_MemWrite;
   logic        c_o_RegWrite, c_o_MemtoReg;
   logic [4:0]  c_o_wb_addr;
   logic [1:0]  c_o_fwd_a, c_o_fwd_b;

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;
   int n;

   // instruction words held in ID/EX, EX/MEM, MEM/WB (BUB = bubble)
   logic [31:0] m [3] = '{BUB, BUB, BUB};

   pipe_ctrl #(.IWIDTH(32), .AWIDTH(5)) dut (
      .c_clk(c_clk), .c_rst(c_rst), .c_i_ce(c_i_ce),
      .c_i_instr(c_i_instr), .c_i_branch_taken(c_i_branch_taken),
      .c_o_stall(c_o_stall), .c_o_flush(c_o_flush),
      .c_o_RegDst(c_o_RegDst), .c_o_ALUSrc(c_o_ALUSrc),
      .c_o_alu_op(c_o_alu_op), .c_o_MemRead(c_o_MemRead),
      .c_o_MemWrite(c_o_MemWrite), .c_o_RegWrite(c_o_RegWrite),
      .c_o_MemtoReg(c_o_MemtoReg), .c_o_wb_addr(c_o_wb_addr),
      .c_o_fwd_a(c_o_fwd_a), .c_o_fwd_b(c_o_fwd_b)
   );

   always #5 c_clk = ~c_clk;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   function automatic bit is_r(input logic [31:0] w);
      return w[31:26] == 6'h00;
   endfunction
   function automatic bit is_lw(input logic [31:0] w);
      return w[31:26] == 6'h23;
   endfunction
   function automatic bit is_sw(input logic [31:0] w);
      return w[31:26] == 6'h2B;
   endfunction
   function automatic bit is_beq(input logic [31:0] w);
      return w[31:26] == 6'h04;
   endfunction
   function automatic bit is_addi(input logic [31:0] w);
      return w[31:26] == 6'h08;
   endfunction
   function automatic bit writes(input logic [31:0] w);
      return is_r(w) || is_lw(w) || is_addi(w);
   endfunction
   function automatic logic [4:0] dst(input logic [31:0] w);
      return is_r(w) ? w[15:11] : w[20:16];
   endfunction
   function automatic bit wr_to(input logic [31:0] w, input logic [4:0] r);
      return writes(w) && dst(w) != 5'd0 && dst(w) == r;
   endfunction
   function automatic bit reads_rt(input logic [31:0] w);
      return is_r(w) || is_sw(w) || is_beq(w);
   endfunction
   function automatic bit dep(input logic [31:0] i, input logic [31:0] w);
      return wr_to(w, i[25:21]) || (reads_rt(i) && wr_to(w, i[20:16]));
   endfunction

   function automatic bit m_hazard();
`ifdef PIPE_CTRL_FORWARDING_EN
      return is_lw(m[0]) && dep(c_i_instr, m[0]);
`else
      return dep(c_i_instr, m[0]) || dep(c_i_instr, m[1]) ||
             dep(c_i_instr, m[2]);
`endif
   endfunction
   function automatic bit m_flush();
      return c_i_ce && c_i_branch_taken;
   endfunction
   function automatic bit m_stall();
      return c_i_ce && !c_i_branch_taken && m_hazard();
   endfunction
   function automatic logic [1:0] m_fwd(input logic [4:0] r);
`ifdef PIPE_CTRL_FORWARDING_EN
      if (wr_to(m[1], r)) return 2'b10;
      if (wr_to(m[2], r)) return 2'b01;
`endif
      return {1'b0, r[0] & 1'b0};
   endfunction
   function automatic logic [1:0] m_aluop(input logic [31:0] w);
      if (is_r(w)) return 2'b10;
      if (is_beq(w)) return 2'b01;
      return 2'b00;
   endfunction

   // model: shift instruction words through the three stages
   always @(posedge c_clk or negedge c_rst) begin
      if (!c_rst) begin
         m[0] <= BUB;
         m[1] <= BUB;
         m[2] <= BUB;
      end else if (c_i_ce) begin
         m[2] <= m[1];
         m[1] <= m[0];
         m[0] <= (m_flush() || m_stall()) ? BUB : c_i_instr;
      end
   end

   // compare every output against the model each falling edge
   always @(negedge c_clk) begin
      if (chk_en) begin
         chk("stall", c_o_stall, m_stall());
         chk("flush", c_o_flush, m_flush());
         chk("RegDst", c_o_RegDst, is_r(m[0]));
         chk("ALUSrc", c_o_ALUSrc,
             is_lw(m[0]) || is_sw(m[0]) || is_addi(m[0]));
         chk("alu_op", c_o_alu_op, m_aluop(m[0]));
         chk("MemRead", c_o_MemRead, is_lw(m[1]));
         chk("MemWrite", c_o_MemWrite, is_sw(m[1]));
         chk("RegWrite", c_o_RegWrite, writes(m[2]));
         chk("MemtoReg", c_o_MemtoReg, is_lw(m[2]));
         chk("wb_addr", c_o_wb_addr, writes(m[2]) ? dst(m[2]) : 5'd0);
         chk("fwd_a", c_o_fwd_a, m_fwd(m[0][25:21]));
         chk("fwd_b", c_o_fwd_b, m_fwd(m[0][20:16]));
      end
   end

   task automatic set_in(input logic [31:0] i, input logic b);
      @(posedge c_clk);
      #1;
      c_i_instr = i;
      c_i_branch_taken = b;
      @(negedge c_clk);
      #1;
   endtask

   task automatic nops(input int k);
      repeat (k) set_in(NOP, 1'b0);
   endtask

   task automatic issue(input logic [31:0] i, output int cnt);
      cnt = 0;
      set_in(i, 1'b0);
      while (m_stall() && cnt < 8) begin
         cnt++;
         set_in(i, 1'b0);
      end
      if (cnt >= 8) chk("stall_bound", cnt, 0);
   endtask

   initial begin
      repeat (2) @(posedge c_clk);
      #1;
      chk_en = 1'b1;
      chk("rst_RegWrite", c_o_RegWrite, 0);
      chk("rst_wb_addr", c_o_wb_addr, 0);
      chk("rst_alu_op", c_o_alu_op, 0);
      c_rst = 1'b1;
      @(negedge c_clk);
      #1;
      chk("rel_stall", c_o_stall, 0);
      chk("rel_RegDst", c_o_RegDst, 0);
      chk("rel_MemRead", c_o_MemRead, 0);

      // single R-type: EX after 1 cycle, WB after 3
      issue(ADD9, n);
      chk("add_nostall", n, 0);
      set_in(NOP, 1'b0);
      chk("add_RegDst", c_o_RegDst, 1);
      chk("add_alu_op", c_o_alu_op, 2'b10);
      set_in(NOP, 1'b0);
      set_in(NOP, 1'b0);
      chk("add_RegWrite", c_o_RegWrite, 1);
      chk("add_wb_addr", c_o_wb_addr, 9);

      // load-use
      nops(4);
      set_in(LW8, 1'b0);
      set_in(ADD9, 1'b0);
      chk("lu_stall", c_o_stall, 1);
      set_in(ADD9, 1'b0);
      chk("lu_bub_RegDst", c_o_RegDst, 0);
      chk("lu_bub_alu_op", c_o_alu_op, 0);
      chk("lu_MemRead", c_o_MemRead, 1);
`ifdef PIPE_CTRL_FORWARDING_EN
      chk("lu_stall_end", c_o_stall, 0);
      set_in(NOP, 1'b0);
      chk("lu_fwd_a", c_o_fwd_a, 2'b01);
      chk("lu_fwd_b", c_o_fwd_b, 2'b01);
`else
      chk("lu_stall2", c_o_stall, 1);
      set_in(ADD9, 1'b0);
      chk("lu_stall3", c_o_stall, 1);
      set_in(ADD9, 1'b0);
      chk("lu_stall_end", c_o_stall, 0);
      set_in(NOP, 1'b0);
      chk("lu_fwd_a", c_o_fwd_a, 2'b00);
`endif

      // back-to-back RAW
      nops(4);
      set_in(ADD9, 1'b0);
      issue(ADD10, n);
`ifdef PIPE_CTRL_FORWARDING_EN
      chk("raw_stalls", n, 0);
      set_in(NOP, 1'b0);
      chk("raw_fwd_a", c_o_fwd_a, 2'b10);
      chk("raw_fwd_b", c_o_fwd_b, 2'b10);
`else
      chk("raw_stalls", n, 3);
      set_in(NOP, 1'b0);
      chk("raw_fwd_b", c_o_fwd_b, 2'b00);
`endif

      // taken branch coinciding with a load-use hazard
      nops(4);
      set_in(BEQ, 1'b0);
      set_in(LW8, 1'b0);
      chk("br_alu_op", c_o_alu_op, 2'b01);
      set_in(ADD9, 1'b1);
      chk("br_flush", c_o_flush, 1);
      chk("br_stall", c_o_stall, 0);
      set_in(ADD9, 1'b0);
      chk("br_bub_RegDst", c_o_RegDst, 0);
      chk("br_bub_ALUSrc", c_o_ALUSrc, 0);
      chk("br_bub_alu_op", c_o_alu_op, 0);
      nops(4);

      // clock enable low freezes state and masks stall/flush
      set_in(ADD9, 1'b0);
      set_in(NOP, 1'b0);
      c_i_ce = 1'b0;
      c_i_branch_taken = 1'b1;
      #1;
      chk("ce_flush", c_o_flush, 0);
      chk("ce_stall", c_o_stall, 0);
      set_in(NOP, 1'b1);
      chk("ce_hold_RegDst", c_o_RegDst, 1);
      chk("ce_hold_MemRead", c_o_MemRead, 0);
      c_i_ce = 1'b1;
      c_i_branch_taken = 1'b0;
      nops(4);

      // reset mid-stream with lw in EX/MEM
      set_in(LW8, 1'b0);
      set_in(NOP, 1'b0);
      set_in(NOP, 1'b0);
      chk("mid_MemRead_pre", c_o_MemRead, 1);
      c_rst = 1'b0;
      #1;
      chk("mid_MemRead", c_o_MemRead, 0);
      chk("mid_RegWrite", c_o_RegWrite, 0);
      @(posedge c_clk);
      #1;
      c_rst = 1'b1;
      set_in(NOP, 1'b0);
      chk("mid_no_wb", c_o_RegWrite, 0);
      chk("mid_wb_addr", c_o_wb_addr, 0);
      nops(3);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control and hazard unit for the five-stage MIPS datapath. It decodes the IF/ID instruction into the datapath's control signals and carries them through ID/EX, EX/MEM and MEM/WB control registers, so each stage sees its own bits. It also detects load-use and RAW hazards (stall plus bubble), flushes on a taken branch, and drives the ALU operand forwarding selects. This replaces the static control inputs currently driven from outside the datapath.

## Interface
Parameters:
- `IWIDTH`, 32, instruction width
- `AWIDTH`, 5, register-index width

Ports:
- `c_clk`  in  1  clock; all state on rising edge
- `c_rst`  in  1  reset, asynchronous, active-low
- `c_i_ce`  in  1  advance enable; 0 freezes all control registers
- `c_i_instr`  in  IWIDTH  instruction in IF/ID
- `c_i_branch_taken`  in  1  beq resolved taken in EX
- `c_o_stall`  out  1  hold PC and IF/ID
- `c_o_flush`  out  1  squash IF/ID
- `c_o_RegDst`, `c_o_ALUSrc`  out  1 each  EX-stage controls (ID/EX)
- `c_o_alu_op`  out  2  EX-stage ALU class: 00 add, 01 sub, 10 funct
- `c_o_MemRead`, `c_o_MemWrite`  out  1 each  MEM-stage controls (EX/MEM)
- `c_o_RegWrite`, `c_o_MemtoReg`  out  1 each  WB-stage controls (MEM/WB)
- `c_o_wb_addr`  out  AWIDTH  destination register in MEM/WB
- `c_o_fwd_a`, `c_o_fwd_b`  out  2 each  ALU operand select: 00 regfile, 01 MEM/WB, 10 EX/MEM

## Operation
- Decode opcode `c_i_instr[31:26]`:
  - R 000000: RegDst, RegWrite, alu_op 10
  - lw 100011: ALUSrc, MemRead, MemtoReg, RegWrite, alu_op 00
  - sw 101011: ALUSrc, MemWrite, alu_op 00
  - beq 000100: alu_op 01
  - addi 001000: ALUSrc, RegWrite, alu_op 00
  - any other opcode: all controls 0 (NOP)
- Destination register: rd `[15:11]` when RegDst, else rt `[20:16]`. Destination 0 never counts as a write for hazard or forwarding purposes.
- Source registers: rs is always read. rt is read only by R, sw and beq.
- Registers ID/EX, EX/MEM and MEM/WB each hold their control bits plus the destination; ID/EX also holds rs and rt.
- Load-use hazard: ID/EX MemRead=1 and its destination equals a read source of the IF/ID instruction. Then assert stall, and load a bubble (all control 0) into ID/EX on the next edge.
- Flush: `c_i_branch_taken`=1 drives `c_o_flush`=1 and loads a bubble into ID/EX. Flush takes priority over stall (stall forced 0).
- Forwarding for operand A (using ID/EX rs):
  - EX/MEM RegWrite and destination match → 10
  - otherwise MEM/WB RegWrite and destination match → 01
  - otherwise 00
- Operand B uses the same rule with ID/EX rt.
- `c_i_ce`=0: registers hold; stall and flush are forced to 0.

## Timing
- Reset values: every control register cleared. All outputs are 0, including fwd selects 00 and `c_o_wb_addr` 0.
- Stall, flush and fwd are combinational from current register state and `c_i_instr`.
- Stage controls appear 1, 2 and 3 cycles after the instruction is in IF/ID (EX, MEM and WB respectively).
- A load-use hazard costs exactly 1 stall cycle with forwarding compiled in.
- Reset asserted mid-stream clears all in-flight controls immediately, so no write-back occurs.

## Configuration
- `PIPE_CTRL_FORWARDING_EN` defined: forwarding as above; only load-use stalls.
- Not defined:
  - fwd outputs are tied to 00.
  - Stall asserts while any read source matches a RegWrite destination in ID/EX, EX/MEM or MEM/WB.
  - Each stall cycle inserts a bubble.
  - A dependent instruction immediately after its producer waits 3 cycles.

## Structure
- Shared package `mips_pkg`: opcode constants (`OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_ADDI`), the alu_op encodings, the fwd encodings, and the control-bundle struct.
- One sub-module: `ctrl_decode`, a combinational opcode-to-bundle decoder.
- Pipeline registers, hazard logic and forwarding logic live in `pipe_ctrl`.

## Test plan
- Reset held for 2 cycles, then released with NOP 0x00000000 → all outputs 0, stall 0.
- Instruction 0x01084820 (add $9,$8,$8) followed by NOPs:
  - RegDst=1 and alu_op=10 one cycle later
  - RegWrite=1 and `c_o_wb_addr`=9 three cycles later.
- lw 0x8C080000 then add 0x01084820 (forwarding compiled in):
  - stall=1 for exactly 1 cycle, with a bubble in ID/EX
  - then fwd_a=01 and fwd_b=01.
- add $9 (0x01084820) then add $10,$9,$9 (0x01295020) → fwd_a=fwd_b=10 with no stall. Without the macro, stall=3 cycles.
- beq 0x10000001 with `c_i_branch_taken`=1 asserted in the same cycle as a load-use hazard → flush=1, stall=0, and the next ID/EX controls are all 0.
- Reset pulsed while an lw is in EX/MEM → MemRead and RegWrite read 0 immediately after reset, with no write-back.
